// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank.
`timescale 1ns/1ps
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both 1. Once valid is raised, the source holds valid and its
// payload unchanged until that edge. Ready may rise or fall freely while valid is low.
interface axi_lite_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [2:0]          s_axi_awprot;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [2:0]          s_axi_arprot;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid, input s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, input s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid, output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid, input s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid, output s_axi_rready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid, output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid, input s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid, input s_axi_rready
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: RW/RO registers, self-clearing bits,
// per-register access strobes, SLVERR for addresses past the last register.
`timescale 1ns/1ps
module axi_lite_regbank #(
  parameter int                       DATA_W    = 32,
  parameter int                       ADDR_W    = 8,
  parameter int                       N_REGS    = 8,
  parameter logic [N_REGS-1:0]        RO_MASK   = '0,
  parameter logic [N_REGS-1:0]        SC_MASK   = '0,
  parameter logic [N_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  axi_lite_regbank_if.slave          s_axi,
  output logic [N_REGS*DATA_W-1:0]   reg_out,
  input  logic [N_REGS*DATA_W-1:0]   reg_in,
  output logic [N_REGS-1:0]          reg_wr_stb,
  output logic [N_REGS-1:0]          reg_rd_stb
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic              r_aw_full;
  logic [IDX_W-1:0]  r_aw_idx;
  logic              r_w_full;
  logic [DATA_W-1:0] r_w_data;
  logic [STRB_W-1:0] r_w_strb;
  logic [DATA_W-1:0] r_regs [N_REGS];
  logic [N_REGS-1:0] r_sc_pend;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [N_REGS-1:0] r_wr_stb;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic [N_REGS-1:0] r_rd_stb;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_commit;
  logic [IDX_W-1:0]  w_ar_idx;
  logic [N_REGS-1:0] w_wr_hit;
  logic [N_REGS-1:0] w_wr_sel;
  logic [N_REGS-1:0] w_rd_sel;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_unused;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_rst_sync <= 2'b00;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Ready/valid outputs come only from flops, so no input reaches them combinationally.
  assign s_axi.s_axi_awready = w_rst_n && !r_aw_full && !r_bvalid;
  assign s_axi.s_axi_wready  = w_rst_n && !r_w_full && !r_bvalid;
  assign s_axi.s_axi_arready = w_rst_n && !r_rvalid;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign reg_wr_stb          = r_wr_stb;
  assign reg_rd_stb          = r_rd_stb;

  assign w_aw_hs  = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
  assign w_w_hs   = s_axi.s_axi_wvalid && s_axi.s_axi_wready;
  assign w_ar_hs  = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
  assign w_commit = r_aw_full && r_w_full && !r_bvalid;
  assign w_ar_idx = s_axi.s_axi_araddr[ADDR_W-1:ADDR_LSB];

  // Protection bits and byte-offset address bits carry no meaning here.
  assign w_unused = &{1'b0, s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                      s_axi.s_axi_awaddr[ADDR_LSB-1:0], s_axi.s_axi_araddr[ADDR_LSB-1:0]};

  // Address decode for both channels; an index matching no register is out of range.
  always_comb begin
    w_wr_hit = '0;
    w_rd_sel = '0;
    w_rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (r_aw_idx == IDX_W'(i)) w_wr_hit[i] = 1'b1;
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_sel[i] = 1'b1;
        w_rd_val    = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : r_regs[i];
      end
    end
    w_wr_sel = w_wr_hit & ~RO_MASK;
  end

  // RO slices never expose the internal (unused) storage.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DATA_W +: DATA_W] = r_regs[i];
    end
  end

  // One-entry AW and W holding buffers; either can fill first, both drain at commit.
  always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi.s_axi_awaddr[ADDR_W-1:ADDR_LSB];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s_axi.s_axi_wdata;
        r_w_strb <= s_axi.s_axi_wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
    end
  end

  // Register storage: byte-strobed commit, self-clear one cycle later unless rewritten.
  always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      r_sc_pend <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (w_commit && w_wr_sel[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (r_w_strb[b]) r_regs[i][b*8 +: 8] <= r_w_data[b*8 +: 8];
          end
        end else if (r_sc_pend[i]) begin
          r_regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        end
      end
      r_sc_pend <= (w_commit ? w_wr_sel : '0) & SC_MASK;
    end
  end

  // Write response and write strobe; a response is held until bready.
  always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_wr_stb <= '0;
    end else begin
      r_wr_stb <= w_commit ? w_wr_sel : '0;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (|w_wr_hit) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axi.s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read response captured at the AR handshake; data stays frozen until rready.
  always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rd_stb <= '0;
    end else begin
      r_rd_stb <= w_ar_hs ? w_rd_sel : '0;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
        r_rresp  <= (|w_rd_sel) ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && s_axi.s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed cases plus randomized traffic
// compared against an array model of the register file.
`timescale 1ns/1ps
module tb_axi_lite_regbank;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int N_REGS = 8;
  localparam int IMG_W  = N_REGS * DATA_W;
  localparam logic [N_REGS-1:0] RO_MASK = 8'b0000_0100;
  localparam logic [N_REGS-1:0] SC_MASK = 8'b0000_1000;
  localparam logic [IMG_W-1:0] RESET_VAL = {32'h7777_0007, 32'h0000_0000, 32'h5A5A_0001,
                                            32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFFF,
                                            32'h0000_0000, 32'h0000_0000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IMG_W-1:0]  reg_out;
  logic [IMG_W-1:0]  reg_in;
  logic [N_REGS-1:0] reg_wr_stb;
  logic [N_REGS-1:0] reg_rd_stb;

  axi_lite_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axi_lite_regbank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REGS(N_REGS),
    .RO_MASK(RO_MASK), .SC_MASK(SC_MASK), .RESET_VAL(RESET_VAL)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .s_axi(bus),
    .reg_out(reg_out),
    .reg_in(reg_in),
    .reg_wr_stb(reg_wr_stb),
    .reg_rd_stb(reg_rd_stb)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_regs [N_REGS];

  task automatic check_val(input string tag, input logic [IMG_W-1:0] got, input logic [IMG_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_REGS; i++) m_regs[i] = RESET_VAL[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [IMG_W-1:0] model_image();
    logic [IMG_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_REGS; i++) if (!RO_MASK[i]) v[i*DATA_W +: DATA_W] = m_regs[i];
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [3:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] out_slice(input int idx);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REGS; i++) if (i == idx) r = reg_out[i*DATA_W +: DATA_W];
    return r;
  endfunction

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int lat,
                           output logic [7:0] stb_b, output logic [7:0] stb_n,
                           output logic [31:0] val_b, output logic [31:0] val_n);
    int idx;
    idx = int'(addr[7:2]);
    fork
      begin : aw_drv
        bit hs;
        hs = 1'b0;
        repeat (aw_dly) @(negedge clk);
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
          hs = bus.s_axi_awready;
          @(negedge clk);
        end
        bus.s_axi_awvalid = 1'b0;
        check_val("aw_handshake", IMG_W'(hs), IMG_W'(1));
      end
      begin : w_drv
        bit hs;
        hs = 1'b0;
        repeat (w_dly) @(negedge clk);
        bus.s_axi_wdata  = data;
        bus.s_axi_wstrb  = strb;
        bus.s_axi_wvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
          hs = bus.s_axi_wready;
          @(negedge clk);
        end
        bus.s_axi_wvalid = 1'b0;
        check_val("w_handshake", IMG_W'(hs), IMG_W'(1));
      end
    join
    lat = 0;
    while (!bus.s_axi_bvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    resp  = bus.s_axi_bresp;
    stb_b = reg_wr_stb;
    val_b = out_slice(idx);
    bus.s_axi_bready = (b_dly == 0);
    @(negedge clk);
    stb_n = reg_wr_stb;
    val_n = out_slice(idx);
    if (b_dly > 0) begin
      for (int k = 1; k < b_dly; k++) begin
        check_val("bvalid_hold", IMG_W'(bus.s_axi_bvalid), IMG_W'(1));
        check_val("awready_hold", IMG_W'(bus.s_axi_awready), IMG_W'(0));
        check_val("wready_hold", IMG_W'(bus.s_axi_wready), IMG_W'(0));
        @(negedge clk);
      end
      bus.s_axi_bready = 1'b1;
      @(negedge clk);
    end
    bus.s_axi_bready = 1'b0;
    check_val("bvalid_clear", IMG_W'(bus.s_axi_bvalid), IMG_W'(0));
  endtask

  task automatic axi_read(input logic [7:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output int lat,
                          output logic [7:0] stb_b, output logic [7:0] stb_n);
    bit hs;
    hs = 1'b0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      hs = bus.s_axi_arready;
      @(negedge clk);
    end
    bus.s_axi_arvalid = 1'b0;
    check_val("ar_handshake", IMG_W'(hs), IMG_W'(1));
    lat = 0;
    while (!bus.s_axi_rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    data  = bus.s_axi_rdata;
    resp  = bus.s_axi_rresp;
    stb_b = reg_rd_stb;
    bus.s_axi_rready = (r_dly == 0);
    @(negedge clk);
    stb_n = reg_rd_stb;
    if (r_dly > 0) begin
      for (int k = 1; k < r_dly; k++) begin
        check_val("rvalid_hold", IMG_W'(bus.s_axi_rvalid), IMG_W'(1));
        check_val("rdata_hold", IMG_W'(bus.s_axi_rdata), IMG_W'(data));
        @(negedge clk);
      end
      bus.s_axi_rready = 1'b1;
      @(negedge clk);
    end
    bus.s_axi_rready = 1'b0;
    check_val("rvalid_clear", IMG_W'(bus.s_axi_rvalid), IMG_W'(0));
  endtask

  // Full write with model update and all write-side comparisons.
  task automatic do_write(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0]  resp;
    logic [7:0]  stb_b, stb_n;
    logic [31:0] val_b, val_n, exp_b, exp_n;
    int lat, idx;
    bit in_range, rw;
    idx      = int'(addr[7:2]);
    in_range = (idx < N_REGS);
    rw       = in_range && !RO_MASK[idx % N_REGS];
    exp_b    = 32'h0;
    exp_n    = 32'h0;
    if (rw) begin
      exp_b = merge(m_regs[idx], data, strb);
      exp_n = SC_MASK[idx] ? RESET_VAL[idx*DATA_W +: DATA_W] : exp_b;
      m_regs[idx] = exp_n;
    end
    axi_write(addr, data, strb, aw_dly, w_dly, b_dly, resp, lat, stb_b, stb_n, val_b, val_n);
    check_val({tag, "_bresp"}, IMG_W'(resp), in_range ? IMG_W'(0) : IMG_W'(2));
    check_val({tag, "_blat"}, IMG_W'(lat), IMG_W'(1));
    check_val({tag, "_wrstb"}, IMG_W'(stb_b), rw ? IMG_W'(8'(1) << idx) : IMG_W'(0));
    check_val({tag, "_wrstb_after"}, IMG_W'(stb_n), IMG_W'(0));
    check_val({tag, "_regout_b"}, IMG_W'(val_b), IMG_W'(exp_b));
    check_val({tag, "_regout_n"}, IMG_W'(val_n), IMG_W'(exp_n));
    check_val({tag, "_image"}, reg_out, model_image());
  endtask

  // Full read through the expected-data queue.
  task automatic do_read(input string tag, input logic [7:0] addr, input int r_dly);
    logic [1:0]  resp;
    logic [7:0]  stb_b, stb_n;
    logic [31:0] data, exp_d;
    int lat, idx;
    bit in_range;
    idx      = int'(addr[7:2]);
    in_range = (idx < N_REGS);
    if (!in_range)                exp_q.push_back(32'h0);
    else if (RO_MASK[idx])        exp_q.push_back(reg_in[idx*DATA_W +: DATA_W]);
    else                          exp_q.push_back(m_regs[idx]);
    axi_read(addr, r_dly, data, resp, lat, stb_b, stb_n);
    exp_d = exp_q.pop_front();
    check_val({tag, "_rdata"}, IMG_W'(data), IMG_W'(exp_d));
    check_val({tag, "_rresp"}, IMG_W'(resp), in_range ? IMG_W'(0) : IMG_W'(2));
    check_val({tag, "_rlat"}, IMG_W'(lat), IMG_W'(0));
    check_val({tag, "_rdstb"}, IMG_W'(stb_b), in_range ? IMG_W'(8'(1) << idx) : IMG_W'(0));
    check_val({tag, "_rdstb_after"}, IMG_W'(stb_n), IMG_W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata  = '0; bus.s_axi_wstrb  = '0; bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    for (int i = 0; i < N_REGS; i++) reg_in[i*DATA_W +: DATA_W] = $urandom;
    reg_in[2*DATA_W +: DATA_W] = 32'h00C0_FFEE;
    model_reset();

    repeat (3) @(negedge clk);
    check_val("rst_awready", IMG_W'(bus.s_axi_awready), IMG_W'(0));
    check_val("rst_wready", IMG_W'(bus.s_axi_wready), IMG_W'(0));
    check_val("rst_arready", IMG_W'(bus.s_axi_arready), IMG_W'(0));
    check_val("rst_bvalid", IMG_W'(bus.s_axi_bvalid), IMG_W'(0));
    check_val("rst_rvalid", IMG_W'(bus.s_axi_rvalid), IMG_W'(0));
    check_val("rst_bresp", IMG_W'(bus.s_axi_bresp), IMG_W'(0));
    check_val("rst_rresp", IMG_W'(bus.s_axi_rresp), IMG_W'(0));
    check_val("rst_rdata", IMG_W'(bus.s_axi_rdata), IMG_W'(0));
    check_val("rst_wrstb", IMG_W'(reg_wr_stb), IMG_W'(0));
    check_val("rst_rdstb", IMG_W'(reg_rd_stb), IMG_W'(0));
    check_val("rst_image", reg_out, model_image());
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("post_rst_awready", IMG_W'(bus.s_axi_awready), IMG_W'(1));
    check_val("post_rst_arready", IMG_W'(bus.s_axi_arready), IMG_W'(1));

    // AW and W together, then read back
    do_write("wr_reg1", 8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read("rd_reg1", 8'h04, 0);

    // W three cycles ahead of AW with a partial strobe
    do_write("wr_reg0_full", 8'h00, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
    do_write("wr_reg0_part", 8'h00, 32'h1234_5678, 4'h3, 3, 0, 0);
    check_val("reg0_merged", IMG_W'(out_slice(0)), IMG_W'(32'hAAAA_5678));
    do_read("rd_reg0", 8'h02, 1);

    // RO register: write discarded, read returns hardware value
    do_write("wr_ro2", 8'h08, 32'h1111_1111, 4'hF, 1, 0, 0);
    do_read("rd_ro2", 8'h08, 0);

    // Out of range
    do_write("wr_oor", 8'hFC, 32'h5555_5555, 4'hF, 0, 2, 0);
    do_read("rd_oor", 8'hFC, 2);

    // Self-clearing register with a long bready stall, then a normal write
    do_write("wr_sc3", 8'h0C, 32'h0000_0001, 4'hF, 0, 0, 10);
    do_write("wr_after_stall", 8'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    do_read("rd_reg4", 8'h10, 0);

    // Randomized mix
    for (int it = 0; it < 80; it++) begin
      int idx;
      logic [7:0] addr;
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < N_REGS; i++) reg_in[i*DATA_W +: DATA_W] = $urandom;
      end
      idx = int'($urandom_range(0, 10));
      if (idx == 10) idx = 63;
      addr = 8'(idx * 4 + int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1)
        do_write("rnd_wr", addr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read("rnd_rd", addr, int'($urandom_range(0, 2)));
    end

    // Reset between AW and W handshakes: transaction abandoned
    bus.s_axi_awaddr  = 8'h18;
    bus.s_axi_awvalid = 1'b1;
    begin
      bit hs;
      hs = 1'b0;
      for (int n = 0; n < 50 && !hs; n++) begin
        hs = bus.s_axi_awready;
        @(negedge clk);
      end
      check_val("midrst_aw_handshake", IMG_W'(hs), IMG_W'(1));
    end
    bus.s_axi_awvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_awready_low", IMG_W'(bus.s_axi_awready), IMG_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check_val("midrst_image", reg_out, model_image());
    for (int k = 0; k < 4; k++) begin
      check_val("midrst_no_bvalid", IMG_W'(bus.s_axi_bvalid), IMG_W'(0));
      @(negedge clk);
    end
    // W alone first: if a stale AW survived, this would commit early
    do_write("wr_after_rst", 8'h18, 32'h0BAD_C0DE, 4'hF, 6, 0, 0);
    do_read("rd_after_rst", 8'h18, 0);
    do_read("rd_reg5_reset", 8'h14, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop if something never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
